// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master bridge among NREQ local requesters.
// A round-robin arbiter grants one request at a time; the FSM issues it to the
// bridge, waits for completion and returns rdata/err with a one-cycle done pulse.
// Optional WAIT-state timeout: define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 8,
  parameter int unsigned TMO_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               transfer,
  output logic               READ_WRITE,
  output logic [AW-1:0]      apb_write_paddr,
  output logic [AW-1:0]      apb_read_paddr,
  output logic [DW-1:0]      apb_write_data,
  input  logic               PENABLE,
  input  logic               PREADY,
  input  logic               PSLVERR,
  input  logic [DW-1:0]      apb_read_data_out
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, gidx, pick_idx, cand;
  logic          pick_vld;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          cmpl, early_err, tmo_hit;

  // Reject unsupported configurations at elaboration
  if (NREQ < 2 || NREQ > 8 || TMO_CYCLES < 1) begin : g_bad_param
    $error("apb_req_arbiter: NREQ must be 2..8 and TMO_CYCLES must be >= 1");
  end

  // Round-robin pick: first set req at or after ptr, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Select the picked requester's command fields
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == IW'(k)) begin
        sel_write = req_write[k];
        sel_addr  = req_addr[k*AW +: AW];
        sel_wdata = req_wdata[k*DW +: DW];
      end
    end
  end

  assign cmpl      = PENABLE && PREADY;
  assign early_err = PSLVERR && !PENABLE;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // WAIT-cycle counter, zero on every entry into WAIT
  always_ff @(posedge PCLK) begin
    if (PRESET || state != WAIT) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == TW'(TMO_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cmpl || early_err || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered grant, bridge command, response and round-robin pointer
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      grant           <= '0;
      done            <= '0;
      rdata           <= '0;
      err             <= 1'b0;
      transfer        <= 1'b0;
      READ_WRITE      <= 1'b1;
      apb_write_paddr <= '0;
      apb_read_paddr  <= '0;
      apb_write_data  <= '0;
      ptr             <= '0;
      gidx            <= '0;
    end else begin
      done     <= '0;
      transfer <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant           <= NREQ'(1) << pick_idx;
            gidx            <= pick_idx;
            READ_WRITE      <= !sel_write;
            apb_write_paddr <= sel_addr;
            apb_read_paddr  <= sel_addr;
            apb_write_data  <= sel_wdata;
            err             <= 1'b0;
            transfer        <= 1'b1;
          end
        end
        WAIT: begin
          if (cmpl) begin
            err  <= PSLVERR;
            done <= grant;
            if (READ_WRITE) rdata <= apb_read_data_out;
          end else if (early_err) begin
            err  <= 1'b1;
            done <= grant;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            rdata <= '0;
            done  <= grant;
          end
        end
        DONE: begin
          grant <= '0;
          ptr   <= (32'(gidx) == NREQ - 1) ? '0 : gidx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: scoreboard bench for apb_req_arbiter with a simple bridge model.
module tb_apb_req_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 9;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic [NREQ-1:0]    req, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    grant, done;
  logic [DW-1:0]      rdata;
  logic               err, transfer, READ_WRITE;
  logic [AW-1:0]      apb_write_paddr, apb_read_paddr;
  logic [DW-1:0]      apb_write_data;
  logic               PENABLE, PREADY, PSLVERR;
  logic [DW-1:0]      apb_read_data_out;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .err(err), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data), .PENABLE(PENABLE), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .apb_read_data_out(apb_read_data_out)
  );

  always #5 PCLK = ~PCLK;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int            idx;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   model_ptr = 0;

  // Observations from the last serviced transfer
  logic [NREQ-1:0] s_g, s_d;
  logic [AW-1:0]   s_wa, s_ra, s_wa2;
  logic [DW-1:0]   s_wd, s_r;
  logic            s_rw, s_e;
  int              s_wt, s_lat;
  bit              s_ok;

  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic void push_exp(input int i, input logic rd, input logic [AW-1:0] a,
                                   input logic [DW-1:0] rdv, input logic er);
    exp_t x;
    x.idx = i; x.rd = rd; x.addr = a; x.rdata = rdv; x.err = er;
    sb.push_back(x);
    model_ptr = (i + 1) % NREQ;
  endfunction

  // Bridge model: waits for transfer, then answers after 'waits' not-ready ENABLE cycles
  task automatic serve(input int waits, input logic [DW-1:0] prd, input logic perr,
                       input logic early, input logic scramble);
    s_ok = 0; s_wt = 0; s_lat = 0;
    s_g = '0; s_d = '0; s_wa = '0; s_ra = '0; s_wa2 = '0; s_wd = '0; s_r = '0;
    s_rw = 1'b0; s_e = 1'b0;
    while (transfer !== 1'b1 && s_wt < 20) begin @(negedge PCLK); s_wt++; end
    if (transfer !== 1'b1) return;
    s_g = grant; s_wa = apb_write_paddr; s_ra = apb_read_paddr;
    s_rw = READ_WRITE; s_wd = apb_write_data;
    @(negedge PCLK);
    s_lat = 1;
    if (scramble) begin
      req_write = ~req_write; req_addr = ~req_addr; req_wdata = ~req_wdata;
    end
    while (done === '0 && s_lat < 40) begin
      if (early) begin
        PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b1;
      end else if (s_lat - 1 < waits) begin
        PENABLE = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
      end else begin
        PENABLE = 1'b1; PREADY = 1'b1; PSLVERR = perr; apb_read_data_out = prd;
      end
      @(negedge PCLK);
      s_lat++;
    end
    s_d = done; s_e = err; s_r = rdata; s_wa2 = apb_write_paddr;
    s_ok = (done !== '0);
    PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; apb_read_data_out = '0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    vectors++; if ({grant, done, err, transfer} !== '0) begin miscompares++; $display("FAIL reset_ctrl: got grant=%b done=%b err=%b transfer=%b want all 0", grant, done, err, transfer); end
    vectors++; if (READ_WRITE !== 1'b1 || rdata !== '0) begin miscompares++; $display("FAIL reset_rw_rdata: got rw=%b rdata=%h want rw=1 rdata=00", READ_WRITE, rdata); end
    vectors++; if ({apb_write_paddr, apb_read_paddr, apb_write_data} !== '0) begin miscompares++; $display("FAIL reset_bridge: got wa=%h ra=%h wd=%h want 0", apb_write_paddr, apb_read_paddr, apb_write_data); end
    PRESET = 1'b0;
    model_ptr = 0;
    @(negedge PCLK);
  endtask

  task automatic test_single_write();
    exp_t x;
    req_write = 2'b01; req_addr = {9'h1FF, 9'h005}; req_wdata = {8'hFF, 8'hA5};
    push_exp(rr_pick(2'b01), 1'b0, 9'h005, 8'h00, 1'b0);
    req = 2'b01;
    serve(0, 8'h00, 1'b0, 1'b0, 1'b1);
    req = 2'b00;
    x = sb.pop_front();
    vectors++; if (!s_ok) begin miscompares++; $display("FAIL wr_done_seen: got no done want done"); end
    vectors++; if (s_g !== NREQ'(1) << x.idx) begin miscompares++; $display("FAIL wr_grant: got %b want %b", s_g, NREQ'(1) << x.idx); end
    vectors++; if (s_wa !== x.addr || s_ra !== x.addr || s_rw !== 1'b0 || s_wd !== 8'hA5) begin miscompares++; $display("FAIL wr_bridge: got wa=%h ra=%h rw=%b wd=%h want %h %h 0 a5", s_wa, s_ra, s_rw, s_wd, x.addr, x.addr); end
    vectors++; if (s_wa2 !== x.addr) begin miscompares++; $display("FAIL wr_addr_stable: got %h want %h", s_wa2, x.addr); end
    vectors++; if (s_wt !== 1 || s_lat !== 2) begin miscompares++; $display("FAIL wr_timing: got issue_wait=%0d lat=%0d want 1 2", s_wt, s_lat); end
    vectors++; if (s_d !== NREQ'(1) << x.idx || s_e !== x.err) begin miscompares++; $display("FAIL wr_done: got done=%b err=%b want %b %b", s_d, s_e, NREQ'(1) << x.idx, x.err); end
    @(negedge PCLK);
    vectors++; if ({done, grant, transfer} !== '0) begin miscompares++; $display("FAIL wr_pulse_end: got done=%b grant=%b tr=%b want 0", done, grant, transfer); end
  endtask

  task automatic test_slave2_read();
    exp_t x;
    req_write = 2'b00; req_addr = {9'h105, 9'h0F0}; req_wdata = '0;
    push_exp(rr_pick(2'b10), 1'b1, 9'h105, 8'h3C, 1'b0);
    req = 2'b10;
    serve(3, 8'h3C, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    x = sb.pop_front();
    vectors++; if (!s_ok || s_g !== NREQ'(1) << x.idx) begin miscompares++; $display("FAIL rd_grant: got ok=%0d grant=%b want 1 %b", s_ok, s_g, NREQ'(1) << x.idx); end
    vectors++; if (s_wa !== x.addr || s_ra !== x.addr || s_rw !== x.rd) begin miscompares++; $display("FAIL rd_bridge: got wa=%h ra=%h rw=%b want %h %h %b", s_wa, s_ra, s_rw, x.addr, x.addr, x.rd); end
    vectors++; if (s_lat !== 5) begin miscompares++; $display("FAIL rd_wait_len: got %0d want 5", s_lat); end
    vectors++; if (s_d !== NREQ'(1) << x.idx || s_r !== x.rdata || s_e !== x.err) begin miscompares++; $display("FAIL rd_done: got done=%b rdata=%h err=%b want %b %h %b", s_d, s_r, s_e, NREQ'(1) << x.idx, x.rdata, x.err); end
    @(negedge PCLK);
    vectors++; if ({done, grant} !== '0) begin miscompares++; $display("FAIL rd_pulse_end: got done=%b grant=%b want 0", done, grant); end
  endtask

  task automatic test_contention();
    exp_t x;
    int   k;
    req_write = 2'b00; req_addr = {9'h122, 9'h011}; req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      k = rr_pick(2'b11);
      push_exp(k, 1'b1, (k == 1) ? 9'h122 : 9'h011, 8'(16 + i), 1'b0);
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(i % 3, 8'(16 + i), 1'b0, 1'b0, 1'b0);
      if (i == 3) req = 2'b00;
      x = sb.pop_front();
      vectors++; if (!s_ok || s_wt !== 1) begin miscompares++; $display("FAIL cont_issue_%0d: got ok=%0d issue_wait=%0d want 1 1", i, s_ok, s_wt); end
      vectors++; if (s_g !== NREQ'(1) << x.idx || s_d !== s_g) begin miscompares++; $display("FAIL cont_grant_%0d: got grant=%b done=%b want %b", i, s_g, s_d, NREQ'(1) << x.idx); end
      vectors++; if (s_wa !== x.addr || s_r !== x.rdata || s_e !== 1'b0) begin miscompares++; $display("FAIL cont_data_%0d: got addr=%h rdata=%h err=%b want %h %h 0", i, s_wa, s_r, s_e, x.addr, x.rdata); end
      @(negedge PCLK);
      vectors++; if ({done, grant, transfer} !== '0) begin miscompares++; $display("FAIL cont_idle_%0d: got done=%b grant=%b tr=%b want 0", i, done, grant, transfer); end
    end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t x;
    req_write = 2'b00; req_addr = {9'h000, 9'h0AB};
    push_exp(rr_pick(2'b01), 1'b1, 9'h0AB, 8'h00, 1'b1);
    req = 2'b01;
    serve(1000, 8'hEE, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    x = sb.pop_front();
    vectors++; if (!s_ok || s_lat !== TMO + 1) begin miscompares++; $display("FAIL tmo_len: got ok=%0d lat=%0d want 1 %0d", s_ok, s_lat, TMO + 1); end
    vectors++; if (s_d !== NREQ'(1) << x.idx || s_e !== x.err || s_r !== x.rdata) begin miscompares++; $display("FAIL tmo_done: got done=%b err=%b rdata=%h want %b %b %h", s_d, s_e, s_r, NREQ'(1) << x.idx, x.err, x.rdata); end
    @(negedge PCLK);
  endtask
`endif

  task automatic test_slave_error();
    exp_t x;
    req_write = 2'b11; req_addr = {9'h033, 9'h144}; req_wdata = {8'h11, 8'h22};
    push_exp(rr_pick(2'b01), 1'b0, 9'h144, 8'h00, 1'b1);
    req = 2'b01;
    serve(1, 8'h00, 1'b1, 1'b0, 1'b0);
    req = 2'b00;
    x = sb.pop_front();
    vectors++; if (!s_ok || s_d !== NREQ'(1) << x.idx || s_e !== x.err) begin miscompares++; $display("FAIL slverr_done: got ok=%0d done=%b err=%b want 1 %b %b", s_ok, s_d, s_e, NREQ'(1) << x.idx, x.err); end
    @(negedge PCLK);
    vectors++; if ({done, grant, transfer} !== '0) begin miscompares++; $display("FAIL slverr_idle: got done=%b grant=%b tr=%b want 0", done, grant, transfer); end
    push_exp(rr_pick(2'b10), 1'b0, 9'h033, 8'h00, 1'b1);
    req = 2'b10;
    serve(0, 8'h00, 1'b0, 1'b1, 1'b0);
    req = 2'b00;
    x = sb.pop_front();
    vectors++; if (!s_ok || s_lat !== 2 || s_d !== NREQ'(1) << x.idx || s_e !== x.err) begin miscompares++; $display("FAIL early_err: got ok=%0d lat=%0d done=%b err=%b want 1 2 %b %b", s_ok, s_lat, s_d, s_e, NREQ'(1) << x.idx, x.err); end
    @(negedge PCLK);
  endtask

  task automatic test_reset_mid_wait();
    exp_t x;
    int   n = 0;
    req_write = 2'b00; req_addr = {9'h0AA, 9'h055}; req_wdata = {8'h5A, 8'h00};
    req = 2'b01;
    while (transfer !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
    vectors++; if (transfer !== 1'b1) begin miscompares++; $display("FAIL rst_issue: got transfer=%b want 1", transfer); end
    @(negedge PCLK);
    PENABLE = 1'b1; PREADY = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1; req = 2'b00;
    @(negedge PCLK);
    PRESET = 1'b0; PENABLE = 1'b0;
    model_ptr = 0;
    vectors++; if ({grant, transfer, done} !== '0 || READ_WRITE !== 1'b1) begin miscompares++; $display("FAIL rst_mid_wait: got grant=%b tr=%b done=%b rw=%b want 0 0 0 1", grant, transfer, done, READ_WRITE); end
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      vectors++; if ({done, grant} !== '0) begin miscompares++; $display("FAIL rst_no_done_%0d: got done=%b grant=%b want 0", i, done, grant); end
    end
    req_write = 2'b10;
    push_exp(rr_pick(2'b10), 1'b0, 9'h0AA, 8'h00, 1'b0);
    req = 2'b10;
    serve(2, 8'h00, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    x = sb.pop_front();
    vectors++; if (!s_ok || s_g !== NREQ'(1) << x.idx || s_wa !== x.addr || s_wd !== 8'h5A || s_rw !== 1'b0) begin miscompares++; $display("FAIL rst_next_issue: got ok=%0d grant=%b wa=%h wd=%h rw=%b want 1 %b %h 5a 0", s_ok, s_g, s_wa, s_wd, s_rw, NREQ'(1) << x.idx, x.addr); end
    vectors++; if (s_d !== NREQ'(1) << x.idx || s_e !== x.err || s_lat !== 4) begin miscompares++; $display("FAIL rst_next_done: got done=%b err=%b lat=%0d want %b %b 4", s_d, s_e, s_lat, NREQ'(1) << x.idx, x.err); end
    @(negedge PCLK);
  endtask

  initial begin
    PRESET = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; apb_read_data_out = '0;
    test_reset();
    test_single_write();
    test_slave2_read();
    test_contention();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_slave_error();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
